// File: rtl/ibex_instr_resp_pkg.sv
// ibex_instr_resp_pkg
//   Shared types and helpers for the instruction-bus responder.
//   - NopInstr      : reset value of every program word (addi x0, x0, 0)
//   - resp_entry_t  : one queued response (data, stored integrity, error, latency counter)
//   - EntryW        : flat width of resp_entry_t, used on sub-module ports
//   - word_idx_valid: range check of a fetch word index against the memory depth
package ibex_instr_resp_pkg;

  localparam logic [31:0] NopInstr = 32'h00000013;

  typedef struct packed {
    logic [31:0] rdata;
    logic [6:0]  intg;
    logic        err;
    logic [2:0]  cnt;
  } resp_entry_t;

  localparam int unsigned EntryW = $bits(resp_entry_t);

  function automatic logic word_idx_valid(input logic [29:0] idx, input int unsigned depth);
    return {2'b00, idx} < depth;
  endfunction

endpackage

// File: rtl/ibex_instr_resp_queue.sv
// ibex_instr_resp_queue
//   Depth-entry in-order FIFO of resp_entry_t. Each occupied slot carries a
//   latency counter that counts down to 0 (saturating); the loaded value is
//   supplied by the pusher in the entry's cnt field.
//   - clk_i, rst_i   : clock, asynchronous active-high reset
//   - push_i         : write push_entry_i at the tail
//   - push_entry_i   : packed resp_entry_t
//   - pop_i          : drop the head (caller guarantees the queue is non-empty)
//   - count_o        : registered occupancy
//   - head_valid_o   : head slot occupied
//   - head_o         : packed head entry
module ibex_instr_resp_queue
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [EntryW-1:0] push_entry_i,
  input  logic              pop_i,
  output logic [2:0]        count_o,
  output logic              head_valid_o,
  output logic [EntryW-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [2:0]      count_reg;
  logic [Depth-1:0] valid_vec;
  resp_entry_t     entry_vec [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_slot
      logic        slot_valid_reg;
      resp_entry_t slot_entry_reg;
      logic        push_here;
      logic        pop_here;

      assign push_here = push_i && (wr_ptr_reg == PtrW'(gi));
      assign pop_here  = pop_i  && (rd_ptr_reg == PtrW'(gi));

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          slot_valid_reg <= 1'b0;
          slot_entry_reg <= '0;
        end else if (push_here) begin
          slot_valid_reg <= 1'b1;
          slot_entry_reg <= resp_entry_t'(push_entry_i);
        end else begin
          if (pop_here) begin
            slot_valid_reg <= 1'b0;
          end
          if (slot_valid_reg && slot_entry_reg.cnt != 3'd0) begin
            slot_entry_reg.cnt <= slot_entry_reg.cnt - 3'd1;
          end
        end
      end

      assign valid_vec[gi] = slot_valid_reg;
      assign entry_vec[gi] = slot_entry_reg;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_i) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push_i, pop_i})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count_o      = count_reg;
  assign head_valid_o = valid_vec[rd_ptr_reg];
  assign head_o       = entry_vec[rd_ptr_reg];

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// prim_secded_inv_39_32_enc
//   Inverted Hsiao SECDED (39,32) encoder, identical in function to the
//   library primitive of the same name.
//   - data_i : 32-bit data word
//   - data_o : {7 inverted check bits, data_i}
module prim_secded_inv_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  always_comb begin : p_encode
    data_o     = {7'b0, data_i};
    data_o[32] = ^(data_o & 39'h002606BD25);
    data_o[33] = ^(data_o & 39'h00DEBA8050);
    data_o[34] = ^(data_o & 39'h00413D89AA);
    data_o[35] = ^(data_o & 39'h0031234ED1);
    data_o[36] = ^(data_o & 39'h00C2C1323B);
    data_o[37] = ^(data_o & 39'h002DCC624C);
    data_o[38] = ^(data_o & 39'h0098505586);
    // Inversion keeps the all-zero word from having an all-zero codeword.
    data_o     = data_o ^ 39'h2A00000000;
  end

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// ibex_instr_bus_responder
//   Answers the Ibex instruction fetch req/gnt/rvalid protocol from a small
//   word-addressed program memory, with integrity bits, grant stalls and
//   response holds for directed benches.
//   Ports:
//   - clk_i, rst_i          : clock, asynchronous active-high reset
//   - instr_req_i/addr_i    : fetch request and byte address
//   - instr_gnt_o           : request accepted this cycle
//   - instr_rvalid_o        : response valid, with rdata/rdata_intg/err
//   - stall_i               : suppress grant this cycle
//   - resp_hold_i           : suppress response issue this cycle
//   - prog_we/addr/wdata_i  : program-memory write port
//   - intg_corrupt_i        : flip intg bit 0 of the request granted this cycle
//   Build option: define IBEX_INSTR_RESP_INTG_CORRUPT_EN to enable intg_corrupt_i;
//   otherwise it is ignored and integrity is always correct.
module ibex_instr_bus_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned MemDepthWords  = 64,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             instr_req_i,
  input  logic [31:0]                      instr_addr_i,
  output logic                             instr_gnt_o,
  output logic                             instr_rvalid_o,
  output logic [31:0]                      instr_rdata_o,
  output logic [6:0]                       instr_rdata_intg_o,
  output logic                             instr_err_o,
  input  logic                             stall_i,
  input  logic                             resp_hold_i,
  input  logic                             prog_we_i,
  input  logic [$clog2(MemDepthWords)-1:0] prog_addr_i,
  input  logic [31:0]                      prog_wdata_i,
  input  logic                             intg_corrupt_i
);

  localparam int unsigned AddrW = $clog2(MemDepthWords);

  logic [31:0]       mem_reg [MemDepthWords];
  logic [29:0]       fetch_idx;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic [38:0]       enc_data;
  logic              corrupt;
  logic              accept;
  logic              pop;
  logic [2:0]        count;
  logic              head_valid;
  logic [EntryW-1:0] head_flat;
  resp_entry_t       head;
  resp_entry_t       push_entry;

`ifdef IBEX_INSTR_RESP_INTG_CORRUPT_EN
  assign corrupt = intg_corrupt_i;
  logic unused_sig;
  assign unused_sig = ^{instr_addr_i[1:0], enc_data[31:0]};
`else
  assign corrupt = 1'b0;
  logic unused_sig;
  assign unused_sig = ^{instr_addr_i[1:0], enc_data[31:0], intg_corrupt_i};
`endif

  // Program memory. The fetch read is combinational and the write lands on
  // the edge, so a same-cycle grant to the written word sees the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MemDepthWords; i++) begin
        mem_reg[i] <= NopInstr;
      end
    end else if (prog_we_i && (32'(prog_addr_i) < MemDepthWords)) begin
      mem_reg[prog_addr_i] <= prog_wdata_i;
    end
  end

  assign fetch_idx   = instr_addr_i[31:2];
  assign fetch_valid = word_idx_valid(fetch_idx, MemDepthWords);
  assign fetch_data  = fetch_valid ? mem_reg[fetch_idx[AddrW-1:0]] : 32'h0;

  prim_secded_inv_39_32_enc u_enc (
    .data_i (fetch_data),
    .data_o (enc_data)
  );

  // Full is judged on the registered count only, so gnt never depends on rvalid.
  assign instr_gnt_o = instr_req_i & ~stall_i & ~rst_i & (32'(count) < MaxOutstanding);
  assign accept      = instr_req_i & instr_gnt_o;

  always_comb begin
    push_entry       = '0;
    push_entry.rdata = fetch_data;
    push_entry.intg  = enc_data[38:32] ^ {6'b0, corrupt};
    push_entry.err   = ~fetch_valid;
    push_entry.cnt   = 3'(RespLatency - 1);
  end

  ibex_instr_resp_queue #(
    .Depth (MaxOutstanding)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_o       (head_flat)
  );

  assign head = resp_entry_t'(head_flat);

  // Issue only from registered state: a push into an empty queue cannot
  // produce rvalid in the same cycle.
  assign instr_rvalid_o     = head_valid & (head.cnt == 3'd0) & ~resp_hold_i;
  assign pop                = instr_rvalid_o;
  assign instr_rdata_o      = instr_rvalid_o ? head.rdata : 32'h0;
  assign instr_rdata_intg_o = instr_rvalid_o ? head.intg  : 7'h0;
  assign instr_err_o        = instr_rvalid_o ? head.err   : 1'b0;

endmodule

// File: doc/ibex_instr_bus_responder.md
Name: ibex_instr_bus_responder

Overview:
- Synthesizable instruction-memory responder sitting directly upstream of ibex_top's instruction fetch port.
- It answers the core's instruction req/gnt/rvalid protocol from a small word-addressed program memory.
- It returns rdata with inverted-SECDED integrity bits, and supports programmable grant stalls and response holds.
- It replaces hand-sequenced instr_rdata stimulus in directed DV benches.

Parameters:
- MemDepthWords, 64, number of 32-bit program words; word index = instr_addr_i[31:2].
- MaxOutstanding, 2, response-queue depth (accepted but unanswered requests); legal range 1..4.
- RespLatency, 1, minimum cycles from grant to rvalid; legal range >=1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- instr_req_i  in  1  core fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  32  fetched word
- instr_rdata_intg_o  out  7  prim_secded_inv_39_32 check bits of instr_rdata_o
- instr_err_o  out  1  bus error for this response
- stall_i  in  1  suppress grant this cycle
- resp_hold_i  in  1  suppress response issue this cycle
- prog_we_i  in  1  program-memory write strobe
- prog_addr_i  in  $clog2(MemDepthWords)  program word index
- prog_wdata_i  in  32  program word
- intg_corrupt_i  in  1  corrupt integrity of the request granted this cycle (optional feature only)

Behaviour:
- Reset (rst_i high, asynchronous): queue emptied, all outputs 0, every memory word set to 32'h00000013 (NOP). Reset mid-operation drops pending responses with no rvalid.
- Grant (combinational): instr_gnt_o = instr_req_i & ~stall_i & (count < MaxOutstanding).
  - "Full" uses the registered count only: a pop in the same cycle does not free a slot.
  - This keeps gnt independent of rvalid.
- Accept when instr_req_i & instr_gnt_o. One entry is pushed at the tail:
  - If instr_addr_i[31:2] < MemDepthWords: rdata = mem[idx], err = 0.
  - Otherwise: rdata = 0, err = 1.
  - addr[1:0] is ignored.
  - The entry's latency counter loads RespLatency-1.
- Counters: each valid entry's counter decrements every cycle, saturating at 0.
- Issue (combinational from registered state): instr_rvalid_o = head valid & head counter == 0 & ~resp_hold_i.
  - rdata/intg/err are driven from the head when rvalid, else 0.
  - The head pops on issue. Responses are strictly in order.
- Latency: with no stall or hold, the response for a request granted in cycle N appears in cycle N+RespLatency. Back-to-back grants yield back-to-back rvalids.
- Simultaneous push and pop: both happen and count is unchanged. Push into an empty queue never issues in the same cycle.
- Integrity: instr_rdata_intg_o is always the encoding of the driven rdata (all-zero data included). It is computed at push and stored in the entry.
- Program writes: mem[prog_addr_i] <= prog_wdata_i on posedge.
  - A grant to the same word in the same cycle returns the OLD word (read-before-write).
  - prog_addr_i >= MemDepthWords is ignored.
- Read pointer and write pointer wrap modulo MaxOutstanding.

Optional Feature:
- Macro: IBEX_INSTR_RESP_INTG_CORRUPT_EN.
- Defined: intg_corrupt_i sampled at accept inverts bit 0 of the stored intg for that entry only. This exercises the core's instruction integrity alert.
- Undefined: intg_corrupt_i is unused (tied off internally) and integrity is always correct.

Decomposition:
- Package ibex_instr_resp_pkg holds:
  - typedef resp_entry_t {rdata[31:0], intg[6:0], err, cnt[2:0]};
  - localparam NopInstr = 32'h00000013;
  - function word_idx_valid().
- One natural sub-module: ibex_instr_resp_queue, a MaxOutstanding-deep FIFO of resp_entry_t with per-entry counters, push/pop, count and head outputs.
- Integrity encoding uses an existing prim_secded_inv_39_32_enc instance. No new encoder is written.

Test Plan:
- Reset release, req=1 addr=0 continuously, RespLatency=1 -> gnt every cycle; rvalid from the cycle after the first grant; rdata=32'h00000013, intg equal to the encoder of 0x13, err=0.
- Program word 2 = 32'haaaaa1b7, fetch addr 0x8 -> single rvalid one cycle after gnt with rdata=32'haaaaa1b7, err=0.
- Fetch addr 0x100 (MemDepthWords=64) -> rdata=0, err=1, intg=encoder(0).
- resp_hold_i=1 for 5 cycles with req=1, MaxOutstanding=2 -> exactly 2 grants, then gnt=0; after hold drops, 2 in-order rvalids, then grants resume.
- stall_i=1 for 3 cycles -> gnt=0 and no push during stall; prog write to word 0 in the same cycle as a grant to addr 0 -> old data returned.
- rst_i asserted with 2 entries pending -> no rvalid afterwards and outputs 0 immediately (asynchronous). With IBEX_INSTR_RESP_INTG_CORRUPT_EN defined, intg_corrupt_i at grant -> intg bit 0 inverted for that response only.
